// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first ripple over WIDTH cycles through an IDLE/RUN/DONE FSM.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             sum_bit;
  logic             carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carry_nxt;
        acc_d = {sum_bit, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        // On the MSB edge c_q is the carry into the MSB, carry_nxt the carry out.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = {sum_bit, acc_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = c_q ^ carry_nxt;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  addend A; captured on an accepted start.
REQ-006 b  input  WIDTH  addend B; captured on an accepted start.
REQ-007 cin  input  1  carry-in; captured on an accepted start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 sum  output  WIDTH  registered result; held between operations.
REQ-011 cout  output  1  registered carry-out; held between operations.
REQ-012 ovf  output  1  signed-overflow flag; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at an edge: the block SHALL capture a, b and cin into internal shift and carry registers, clear the bit counter, and go to RUN.
REQ-015 IDLE with start=0: the block SHALL remain in IDLE.
REQ-016 Each edge in RUN SHALL process one bit, LSB first:
- sum bit = A[i] ^ B[i] ^ c
- c <= majority(A[i], B[i], c)
- counter increments.
REQ-017 After the edge that processes bit WIDTH-1, the FSM SHALL go to DONE.
REQ-018 RUN SHALL therefore last exactly WIDTH cycles.
REQ-019 On entry to DONE, sum SHALL be loaded with the full assembled result and cout with the final carry.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-021 Latency: start accepted at edge 0 -> done high in the cycle following edge WIDTH.
REQ-022 start SHALL be ignored in RUN and DONE; operands SHALL not be re-captured.
REQ-023 A start request made in DONE SHALL need to be held or reasserted into IDLE to be accepted.
REQ-024 a, b and cin SHALL have no effect except at an accepted start.
REQ-025 sum and cout SHALL change only on entry to DONE or on reset.
REQ-026 The result SHALL equal (a + b + cin) mod 2^WIDTH, with cout as bit WIDTH of the true sum.
REQ-027 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-028 Edge cases:
- all-ones + all-ones with cin=1 -> full carry chain.
- WIDTH=2 -> minimum 2-cycle RUN.
Both SHALL work without special-casing.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE and clear the following to 0:
- busy, done, sum, cout, ovf
- counter, shift registers and carry register.
REQ-030 rst SHALL take priority over start and over any in-progress RUN or DONE.
REQ-031 An aborted operation SHALL produce no done pulse and no change in sum/cout other than the clear.
REQ-032 The first start accepted after rst deasserts SHALL operate normally.

Configuration
REQ-033 Macro SERIAL_ADDER_OVF_EN, when defined, SHALL add port ovf.
REQ-034 With the macro, ovf SHALL be loaded on entry to DONE with (carry into MSB) XOR (carry out of MSB), i.e. two's-complement overflow, and held like sum.
REQ-035 Without the macro, ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-036 a=0x0F, b=0x01, cin=0, start at edge 0 -> busy for 8 cycles, done after edge 8, sum=0x10, cout=0, ovf=0.
REQ-037 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-038 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (macro on); the same build without the macro -> identical sum/cout, no ovf port.
REQ-039 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-040 Run 0x12+0x34, then at edge 3 apply start with a=0xAA, b=0x55:
- first result SHALL be 0x46, cout=0.
- second start SHALL be ignored.
- one done pulse only.
REQ-041 Start 0xF0+0x0F, assert rst at edge 4:
- next cycle: IDLE, busy=0, sum=0x00, no done pulse.
- a new start with 0x01+0x02 -> sum=0x03 after 8 RUN cycles.
